// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: FSM encoding, default widths,
// and the latched note-event bundle.
package synth_pkg;

   localparam int MAXW_DEF = 20;
   localparam int VELW_DEF = 7;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_PICK   = 2'd1;
   localparam state_t ST_ISSUE  = 2'd2;
   localparam state_t ST_SETTLE = 2'd3;

   typedef struct packed {
      logic                on;
      logic [MAXW_DEF-1:0] max;
      logic [VELW_DEF-1:0] vel;
   } evt_t;

endpackage

// File: rtl/voice_pick.sv
// Lowest-index priority encoder over a voice request vector.
module voice_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Note-event dispatcher for a bank of saw-counter voices.
// Optional round-robin voice stealing: define VOICE_STEAL_EN.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NVOICE = 4,
   parameter int MAXW   = MAXW_DEF,
   parameter int VELW   = VELW_DEF
) (
   input  logic                   MHz10,
   input  logic                   nrst,
   input  logic                   en,
   input  logic                   panic,
   input  logic                   evt_valid,
   output logic                   evt_ready,
   input  logic                   evt_on,
   input  logic [MAXW-1:0]        evt_max,
   input  logic [VELW-1:0]        evt_vel,
   input  logic [NVOICE-1:0]      voice_available,
   input  logic [NVOICE-1:0]      voice_pressed,
   input  logic [NVOICE*MAXW-1:0] voice_max,
   output logic [NVOICE-1:0]      start_note,
   output logic                   end_note,
   output logic                   clear,
   output logic [MAXW-1:0]        new_max,
   output logic [VELW-1:0]        velocity,
   output logic                   dropped
);

   localparam int IW = $clog2(NVOICE);

   state_t            state_q, state_d;
   logic              ph_q, ph_d;
   logic              on_q, on_d;
   logic [MAXW-1:0]   max_q, max_d;
   logic [VELW-1:0]   vel_q, vel_d;
   logic [NVOICE-1:0] match_q, match_d;
   logic [NVOICE-1:0] avail_q, avail_d;
   logic [NVOICE-1:0] start_q, start_d;
   logic              end_q, end_d;
   logic              clear_q, clear_d;
   logic [MAXW-1:0]   nmax_q, nmax_d;
   logic [VELW-1:0]   nvel_q, nvel_d;
   logic [NVOICE-1:0] mvec;
   logic [IW-1:0]     m_idx, a_idx;
   logic              m_found, a_found;
`ifdef VOICE_STEAL_EN
   logic [IW-1:0]     steal_q, steal_d;
`else
   logic              drop_q, drop_d;
`endif

   always_comb begin
      for (int i = 0; i < NVOICE; i++) begin
         mvec[i] = voice_pressed[i] &&
                   (voice_max[i*MAXW +: MAXW] == max_q);
      end
   end

   // status is registered first, then encoded, to keep the compare off
   // the encoder path; this makes PICK two cycles long
   voice_pick #(.N(NVOICE), .IW(IW)) u_match (
      .req   (match_q),
      .idx   (m_idx),
      .found (m_found)
   );

   voice_pick #(.N(NVOICE), .IW(IW)) u_avail (
      .req   (avail_q),
      .idx   (a_idx),
      .found (a_found)
   );

   assign evt_ready = en & ~panic & (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      on_d    = on_q;
      max_d   = max_q;
      vel_d   = vel_q;
      match_d = match_q;
      avail_d = avail_q;
      start_d = start_q;
      end_d   = end_q;
      clear_d = clear_q;
      nmax_d  = nmax_q;
      nvel_d  = nvel_q;
`ifdef VOICE_STEAL_EN
      steal_d = steal_q;
`else
      drop_d  = drop_q;
`endif
      if (en) begin
         start_d = '0;
         end_d   = 1'b0;
         clear_d = 1'b0;
`ifndef VOICE_STEAL_EN
         drop_d  = 1'b0;
`endif
         if (panic) begin
            clear_d = 1'b1;
            state_d = ST_SETTLE;
            ph_d    = 1'b0;
`ifdef VOICE_STEAL_EN
            steal_d = '0;
`endif
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (evt_valid) begin
                     on_d    = evt_on & (evt_vel != '0);
                     max_d   = evt_max;
                     vel_d   = evt_vel;
                     ph_d    = 1'b0;
                     state_d = ST_PICK;
                  end
               end
               ST_PICK: begin
                  if (!ph_q) begin
                     match_d = mvec;
                     avail_d = voice_available;
                     ph_d    = 1'b1;
                  end else begin
                     ph_d    = 1'b0;
                     state_d = ST_ISSUE;
                     if (!on_q) begin
                        end_d  = 1'b1;
                        nmax_d = max_q;
                     end else if (m_found) begin
                        start_d[m_idx] = 1'b1;
                        nmax_d = max_q;
                        nvel_d = vel_q;
                     end else if (a_found) begin
                        start_d[a_idx] = 1'b1;
                        nmax_d = max_q;
                        nvel_d = vel_q;
                     end else begin
`ifdef VOICE_STEAL_EN
                        start_d[steal_q] = 1'b1;
                        nmax_d = max_q;
                        nvel_d = vel_q;
                        steal_d = (steal_q == IW'(NVOICE - 1)) ?
                                  '0 : steal_q + 1'b1;
`else
                        drop_d = 1'b1;
`endif
                     end
                  end
               end
               ST_ISSUE:  state_d = ST_SETTLE;
               ST_SETTLE: state_d = ST_IDLE;
               default:   state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge MHz10 or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         ph_q    <= 1'b0;
         on_q    <= 1'b0;
         max_q   <= '0;
         vel_q   <= '0;
         match_q <= '0;
         avail_q <= '0;
         start_q <= '0;
         end_q   <= 1'b0;
         clear_q <= 1'b0;
         nmax_q  <= '0;
         nvel_q  <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         on_q    <= on_d;
         max_q   <= max_d;
         vel_q   <= vel_d;
         match_q <= match_d;
         avail_q <= avail_d;
         start_q <= start_d;
         end_q   <= end_d;
         clear_q <= clear_d;
         nmax_q  <= nmax_d;
         nvel_q  <= nvel_d;
      end
   end

`ifdef VOICE_STEAL_EN
   always_ff @(posedge MHz10 or negedge nrst) begin
      if (!nrst) steal_q <= '0;
      else       steal_q <= steal_d;
   end

   assign dropped = 1'b0;
`else
   always_ff @(posedge MHz10 or negedge nrst) begin
      if (!nrst) drop_q <= 1'b0;
      else       drop_q <= drop_d;
   end

   assign dropped = drop_q & en;
`endif

   // pulses held while disabled fire as soon as en returns
   assign start_note = start_q & {NVOICE{en}};
   assign end_note   = end_q & en;
   assign clear      = clear_q & en;
   assign new_max    = nmax_q;
   assign velocity   = nvel_q;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Note-event dispatcher that drives a bank of `NVOICE` saw-counter voices. It accepts note-on/note-off events from the key/MIDI front end over a valid/ready handshake. It picks a target voice from the voices' `available`/`key_pressed`/`current_max` status and issues single-cycle `start_note` (one-hot), `end_note` (broadcast) or `clear` (broadcast) commands on the shared `new_max`/`velocity` buses. It sits between the event source and the voice bank, upstream of the mixer.

## Interface
Parameters:
- `NVOICE`, 4: number of voices driven (2..16).
- `MAXW`, 20: period (max-count) width.
- `VELW`, 7: velocity width.

Ports:
- `MHz10`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global enable; when low the FSM holds state and all command pulses are 0.
- `panic`  in  1  all-notes-off request.
- `evt_valid`  in  1  event present.
- `evt_ready`  out  1  allocator can accept an event.
- `evt_on`  in  1  1 = note-on, 0 = note-off.
- `evt_max`  in  MAXW  note period (identifies the note).
- `evt_vel`  in  VELW  note-on velocity.
- `voice_available`  in  NVOICE  per-voice `available`.
- `voice_pressed`  in  NVOICE  per-voice `key_pressed`.
- `voice_max`  in  NVOICE*MAXW  per-voice `current_max`; voice i occupies bits [i*MAXW +: MAXW].
- `start_note`  out  NVOICE  one-hot start command.
- `end_note`  out  1  broadcast end command.
- `clear`  out  1  broadcast clear.
- `new_max`  out  MAXW  shared period bus.
- `velocity`  out  VELW  shared velocity bus.
- `dropped`  out  1  one-cycle pulse when a note-on is discarded.

## Operation
- FSM states: IDLE, PICK, ISSUE, SETTLE.
- IDLE: `evt_ready = en`. A handshake (`evt_valid & evt_ready`) latches `evt_on`, `evt_max`, `evt_vel` and moves to PICK.
- A note-on with `evt_vel == 0` is treated as a note-off.
- PICK, note-on target priority:
  1. Lowest index i with `voice_pressed[i]` and `voice_max[i] == evt_max` (retrigger).
  2. Otherwise lowest index with `voice_available[i]`.
  3. Otherwise the steal victim (see Configuration).
- PICK, note-off: no search.
- ISSUE, one cycle:
  - Note-on: `start_note[target]=1`, `new_max=evt_max`, `velocity=evt_vel`.
  - Note-off: `end_note=1`, `new_max=evt_max`. Voices match on their own `current_max`.
- SETTLE: one cycle for voice status registers to update, then IDLE.
- `new_max`/`velocity` are registered. They hold their last driven value outside ISSUE.
- `panic`:
  - Highest priority, in any state including mid-event, provided `en=1`.
  - Next cycle: `clear=1` for exactly one cycle; the latched event is discarded; FSM goes to SETTLE.
  - The steal pointer resets to 0.
  - `panic` held high repeats `clear` every cycle and keeps `evt_ready=0`.
- `en` low: FSM frozen. Pulses forced to 0 and resume when `en` returns. A pending ISSUE fires on the first enabled cycle.

## Timing
- Reset values: state IDLE, `evt_ready=en`, `start_note=0`, `end_note=0`, `clear=0`, `new_max=0`, `velocity=0`, `dropped=0`, steal pointer 0.
- Event accepted at edge k: PICK during cycle k..k+1; command registered at edge k+2 and high for exactly one cycle.
- SETTLE follows; `evt_ready` is high again after edge k+4. Maximum throughput is one event per 4 cycles.
- `start_note` is never more than one bit set. `start_note`, `end_note` and `clear` are never simultaneously high.
- Voice status is sampled only in PICK.

## Configuration
- `VOICE_STEAL_EN` defined:
  - With no matching or available voice, the target is the voice at the round-robin steal pointer.
  - The pointer then advances by 1 modulo `NVOICE` (wraps `NVOICE-1` -> 0).
  - The pointer advances only on steals.
- Undefined:
  - No steal pointer.
  - The ISSUE cycle drives no command and pulses `dropped=1` instead.
  - `new_max`/`velocity` are unchanged.
- With the macro defined, `dropped` is tied 0.

## Structure
- Shared package `synth_pkg`:
  - FSM state typedef.
  - `MAXW`/`VELW` defaults.
  - Event struct {on, max, vel}.
- Sub-module `voice_pick`:
  - Combinational lowest-index priority encoder over an `NVOICE` request vector.
  - Returns index plus found flag.
  - Instantiated twice: retrigger-match vector and available vector.

## Test plan
- Reset, all voices available, note-on max=1000 vel=64 -> `start_note=4'b0001`, `new_max=1000`, `velocity=64` two cycles after handshake; `evt_ready` back high 4 cycles after accept.
- Voices 0,1 busy, voice 2 available, note-on max=500 -> `start_note=4'b0100`.
- Voice 1 pressed with max=700, note-on max=700 vel=90 -> `start_note=4'b0010` (retrigger), not lowest available.
- Note-off max=700, and note-on max=700 vel=0 -> `end_note=1` one cycle, `new_max=700`, `start_note=0`.
- All voices busy, 5 note-ons:
  - With `VOICE_STEAL_EN`: targets 0,1,2,3,0.
  - Without: five `dropped` pulses, no `start_note`.
- `panic` asserted during PICK of a note-on -> `clear=1` one cycle, no `start_note`, steal pointer 0; `nrst` low mid-ISSUE -> all outputs 0 immediately.
